// File: rtl/mult_pipe.sv
// mult_pipe: pipelined signed multiplier, sign-magnitude shift-add.
// One multiplier bit per stage, one result per clock, no backpressure.
// Optional macro MULT_ROUND_EN: round-half-away-from-zero and drop FRAC
// low bits before the sign is reapplied.
// Pipeline: capture (stage 0) -> M add stages -> sign/round stage -> output
// register, so res_rdy rises M+2 edges after the sampling edge.

// One shift-add stage: adds |a| << (K-1) when bit K-1 of |b| is set.
module mult_pipe_stage #(
  parameter int N = 32,
  parameter int M = 32,
  parameter int K = 1
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           en,
  input  logic [N-1:0]   a_mag_i,
  input  logic [M-1:0]   b_mag_i,
  input  logic           sign_i,
  input  logic [N+M-1:0] acc_i,
  output logic [N-1:0]   a_mag_q,
  output logic [M-1:0]   b_mag_q,
  output logic           sign_q,
  output logic [N+M-1:0] acc_q
);
  localparam int W = N + M;

  logic [N-1:0] a_mag_d;
  logic [M-1:0] b_mag_d;
  logic         sign_d;
  logic [W-1:0] acc_d;

  // Load only when the upstream stage holds a valid operation.
  always_comb begin
    a_mag_d = a_mag_q;
    b_mag_d = b_mag_q;
    sign_d  = sign_q;
    acc_d   = acc_q;
    if (en) begin
      a_mag_d = a_mag_i;
      b_mag_d = b_mag_i;
      sign_d  = sign_i;
      acc_d   = acc_i + (b_mag_i[K-1] ? (W'(a_mag_i) << (K-1)) : '0);
    end
  end

  // Stage data registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_mag_q <= '0;
      b_mag_q <= '0;
      sign_q  <= 1'b0;
      acc_q   <= '0;
    end else begin
      a_mag_q <= a_mag_d;
      b_mag_q <= b_mag_d;
      sign_q  <= sign_d;
      acc_q   <= acc_d;
    end
  end
endmodule

module mult_pipe #(
  parameter int N    = 32,
  parameter int M    = 32,
  parameter int FRAC = 0
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           data_rdy,
  input  logic [N-1:0]   a,
  input  logic [M-1:0]   b,
  output logic           res_rdy,
  output logic [N+M-1:0] product
);
  localparam int W = N + M;

  // vld_pipe_q[0] = capture, [1..M] = add stages, [M+1] = sign/round stage.
  logic [M+1:0]        vld_pipe_d, vld_pipe_q;
  logic [M:0][N-1:0]   a_mag;
  logic [M:0][M-1:0]   b_mag;
  logic [M:0]          sign;
  logic [M:0][W-1:0]   acc;

  logic [N-1:0] a_mag0_d, a_mag0_q;
  logic [M-1:0] b_mag0_d, b_mag0_q;
  logic         sign0_d, sign0_q;

  logic [W-1:0] mag;
  logic [W-1:0] fin_d, fin_q;
  logic [W-1:0] product_d, product_q;
  logic         res_rdy_d, res_rdy_q;

  // Valid shifts every cycle; bubbles travel as zeros.
  always_comb vld_pipe_d = {vld_pipe_q[M:0], data_rdy};

  // Capture: magnitudes and result sign. -(2^(N-1)) wraps to 2^(N-1) unsigned.
  always_comb begin
    a_mag0_d = a_mag0_q;
    b_mag0_d = b_mag0_q;
    sign0_d  = sign0_q;
    if (data_rdy) begin
      a_mag0_d = a[N-1] ? -a : a;
      b_mag0_d = b[M-1] ? -b : b;
      sign0_d  = a[N-1] ^ b[M-1];
    end
  end

  assign a_mag[0] = a_mag0_q;
  assign b_mag[0] = b_mag0_q;
  assign sign[0]  = sign0_q;
  assign acc[0]   = '0;

  for (genvar k = 1; k <= M; k++) begin : g_stage
    mult_pipe_stage #(.N(N), .M(M), .K(k)) u_stage (
      .clk     (clk),
      .rstn    (rstn),
      .en      (vld_pipe_q[k-1]),
      .a_mag_i (a_mag[k-1]),
      .b_mag_i (b_mag[k-1]),
      .sign_i  (sign[k-1]),
      .acc_i   (acc[k-1]),
      .a_mag_q (a_mag[k]),
      .b_mag_q (b_mag[k]),
      .sign_q  (sign[k]),
      .acc_q   (acc[k])
    );
  end

`ifdef MULT_ROUND_EN
  // Half an output LSB; zero when FRAC=0 so the shift is a no-op.
  localparam logic [W-1:0] HALF = (W'(1) << FRAC) >> 1;
  // Rounding the magnitude gives round-half-away-from-zero after the sign.
  always_comb mag = (acc[M] + HALF) >> FRAC;
`else
  // Exact product magnitude.
  always_comb mag = acc[M];
`endif

  // Sign application in its own stage keeps the negate off the last adder.
  always_comb begin
    fin_d     = fin_q;
    product_d = product_q;
    res_rdy_d = vld_pipe_q[M+1];
    if (vld_pipe_q[M])   fin_d     = sign[M] ? -mag : mag;
    if (vld_pipe_q[M+1]) product_d = fin_q;
  end

  // Capture, valid pipe and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_pipe_q <= '0;
      a_mag0_q   <= '0;
      b_mag0_q   <= '0;
      sign0_q    <= 1'b0;
      fin_q      <= '0;
      product_q  <= '0;
      res_rdy_q  <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      a_mag0_q   <= a_mag0_d;
      b_mag0_q   <= b_mag0_d;
      sign0_q    <= sign0_d;
      fin_q      <= fin_d;
      product_q  <= product_d;
      res_rdy_q  <= res_rdy_d;
    end
  end

  assign res_rdy = res_rdy_q;
  assign product = product_q;
endmodule

// File: doc/mult_pipe.md
Name: mult_pipe

Overview:
- Pipelined signed integer multiplier. It is the inverse-direction arithmetic companion to the team's pipelined restoring divider.
- Used in the position-calculation path to rescale delay/coordinate terms, e.g. quotient × constant back to the original scale.
- Sign-magnitude shift-add pipeline: one multiplier bit per stage, one result per clock, no backpressure.

Parameters:
- N, 32, width of signed multiplicand a
- M, 32, width of signed multiplier b; also the number of add stages
- FRAC, 0, fractional bits removed when MULT_ROUND_EN is defined; ignored otherwise; legal range 0..N+M-2

Ports:
- clk  in  1  system clock; all state on rising edge
- rstn  in  1  asynchronous active-low reset
- data_rdy  in  1  input valid; a and b are sampled on each rising edge where data_rdy=1
- a  in  N  signed multiplicand
- b  in  M  signed multiplier
- res_rdy  out  1  one-cycle strobe per accepted input; product valid while high
- product  out  N+M  signed result, a×b (rounded/shifted per MULT_ROUND_EN)

Behaviour:
- Reset:
  - rstn=0 asynchronously clears all stage valid bits, accumulators, operand copies and sign bits.
  - res_rdy=0 and product=0 while reset is held and after release.
  - Any in-flight operations are discarded; none emerge after reset.
- Stage 0 (capture), on the edge where data_rdy=1, registers:
  - |a| as N-bit unsigned; |b| as M-bit unsigned
  - sign = a[N-1] XOR b[M-1]
  - acc = 0, valid=1
  - Negation is two's complement. The most-negative value maps to 2^(N-1) (resp. 2^(M-1)), which is representable unsigned.
- Stages k=1..M:
  - If the previous stage is valid: acc += (|a| << (k-1)) when |b|[k-1]=1; |a|, |b| and sign pass forward unchanged.
  - acc is N+M bits unsigned; no overflow is possible.
  - A stage's data registers load only when the incoming valid=1. Valid itself shifts every cycle, so bubbles propagate as valid=0.
- Output stage: when stage M is valid, product <= sign ? -acc : acc (two's complement, N+M bits) and res_rdy <= 1; otherwise res_rdy <= 0 and product holds its last value.
- Latency: res_rdy rises exactly M+2 rising edges after the edge that sampled data_rdy=1.
- Throughput: one operation per clock. Back-to-back data_rdy yields back-to-back res_rdy, in order.
- Zero operand: sign is still computed, but -0 = 0, so product = 0.
- Extremes: (-2^(N-1)) × (-2^(M-1)) = 2^(N+M-2) fits in N+M signed. (-2^(N-1)) × (2^(M-1)-1) is exact.
- The result is always exact; there is no saturation path (without the optional feature).
- a and b may change freely when data_rdy=0; they are not sampled.

Optional Feature:
- Macro: MULT_ROUND_EN.
- Defined:
  - Before the sign is applied in the output stage, magnitude = (acc + (FRAC>0 ? 2^(FRAC-1) : 0)) >> FRAC. This is round half away from zero.
  - product = sign ? -magnitude : magnitude, still N+M bits with the upper bits sign-extended.
  - Rounding adds no cycles; latency is unchanged.
- Undefined: FRAC is ignored and product is the exact a×b.

Test Plan:
- Basic, N=M=8, FRAC=0: a=29, b=5 for one cycle -> res_rdy high for exactly 1 cycle, M+2=10 edges later, product=145; quiet thereafter.
- Signs: a=-29,b=5 -> -145; a=29,b=-5 -> -145; a=-29,b=-5 -> 145; a=0,b=-7 -> 0. All four issued back-to-back -> res_rdy high 4 consecutive cycles, results in order.
- Extremes, N=M=8: a=-128,b=-128 -> 16384; a=-128,b=127 -> -16256; a=127,b=127 -> 16129.
- Bubbles: data_rdy pattern 1,0,1,1,0 with distinct operands -> res_rdy pattern 1,0,1,1,0 shifted by M+2; each product matches its input.
- Reset mid-flight: issue 3 operations, pull rstn low for 1 cycle after 4 cycles, release -> res_rdy and product go 0 immediately and stay 0; no stale result emerges. A new input after release returns correctly at M+2.
- MULT_ROUND_EN defined, N=M=8, FRAC=4:
  - a=29,b=5 (145/16=9.06) -> 9
  - a=-29,b=5 -> -9
  - a=3,b=8 (24/16=1.5) -> 2
  - a=-3,b=8 -> -2
  - latency unchanged
